// File: rtl/shifter_pkg.sv
// Shared encodings and the reference barrel-shift function for the sequential shifter.
// The barrel function works on a MAX_W container so one definition serves any WIDTH up to 64.
package shifter_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } sh_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } sh_state_e;

    typedef struct packed {
        logic [MAX_W-1:0] data;
        logic             carry;
    } sh_res_t;

    // Only the low 'width' bits of data are meaningful; amt must be below width.
    function automatic sh_res_t barrel_shift(input logic [MAX_W-1:0] data,
                                             input logic [1:0]       op,
                                             input int unsigned      amt,
                                             input int unsigned      width);
        sh_res_t          r;
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] src;
        logic [MAX_W-1:0] ext;
        logic [MAX_W-1:0] tmp;
        mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        src  = data & mask;
        tmp  = src >> (width - 1);
        ext  = tmp[0] ? (src | ~mask) : src;
        r.data  = src;
        r.carry = 1'b0;
        if (amt != 0) begin
            case (op)
                SH_LSL: begin
                    r.data  = (src << amt) & mask;
                    tmp     = src >> (width - amt);
                    r.carry = tmp[0];
                end
                SH_LSR: begin
                    r.data  = src >> amt;
                    tmp     = src >> (amt - 1);
                    r.carry = tmp[0];
                end
                SH_ASR: begin
                    r.data  = (ext >> amt) & mask;
                    tmp     = src >> (amt - 1);
                    r.carry = tmp[0];
                end
                default: ;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_shifter_if.sv
// Request/result bundle between the shifter and its client (ALU control).
interface seq_shifter_if #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               start;
    logic [WIDTH-1:0]   in;
    logic [1:0]         op;
    logic [SHAMT_W-1:0] amt;
    logic [WIDTH-1:0]   sout;
    logic               carry;
    logic               busy;
    logic               done;

    modport master (output start, in, op, amt, input sout, carry, busy, done);
    modport slave  (input start, in, op, amt, output sout, carry, busy, done);
endinterface

// File: rtl/shift_step.sv
// Single-position shifter: one bit of LSL/LSR/ASR plus the bit that falls off.
// Latency: combinational.
// Backpressure: none.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    input  sh_op_e           op,
    output logic [WIDTH-1:0] data_nxt,
    output logic             carry_out
);
    always_comb begin
        data_nxt  = data;
        carry_out = 1'b0;
        case (op)
            SH_LSL: begin
                data_nxt  = {data[WIDTH-2:0], 1'b0};
                carry_out = data[WIDTH-1];
            end
            SH_LSR: begin
                data_nxt  = {1'b0, data[WIDTH-1:1]};
                carry_out = data[0];
            end
            SH_ASR: begin
                data_nxt  = {data[WIDTH-1], data[WIDTH-1:1]};
                carry_out = data[0];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter with start/busy/done handshake; SHIFTER_BARREL_EN selects a one-shot barrel build.
// Latency: done after amt edges (iterative, 0 for pass/amt 0) or after the accepting edge (barrel).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, never queued.
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input logic          clk,
    input logic          rst_n,
    seq_shifter_if.slave bus
);
    sh_state_e        state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;

`ifdef SHIFTER_BARREL_EN
    logic [WIDTH-1:0] bar_data;
    logic             bar_carry;

    always_comb begin
        sh_res_t r;
        r         = barrel_shift(MAX_W'(bus.in), bus.op, 32'(bus.amt), WIDTH);
        bar_data  = r.data[WIDTH-1:0];
        bar_carry = r.carry;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    data_d  = bar_data;
                    carry_d = bar_carry;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            carry_q <= carry_d;
        end
    end
`else
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    sh_op_e             op_q, op_d;
    logic [WIDTH-1:0]   step_data;
    logic               step_carry;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data      (data_q),
        .op        (op_q),
        .data_nxt  (step_data),
        .carry_out (step_carry)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    data_d  = bus.in;
                    cnt_d   = bus.amt;
                    op_d    = sh_op_e'(bus.op);
                    carry_d = 1'b0;
                    // Pass and zero-count requests have nothing to iterate.
                    if (sh_op_e'(bus.op) == SH_PASS || bus.amt == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_d  = step_data;
                carry_d = step_carry;
                cnt_d   = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            op_q    <= SH_PASS;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end
`endif

    assign bus.sout  = data_q;
    assign bus.carry = carry_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboarded random/directed bench for seq_shifter; expected results come from an arithmetic model.
module tb_seq_shifter;
    import shifter_pkg::*;

    localparam int W  = 16;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seq_shifter_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();
    seq_shifter #(.WIDTH(W), .SHAMT_W(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [W-1:0] sout;
        logic         carry;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic prev_done = 1'b0;
    logic [W-1:0] last_sout = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    // Shift expressed as multiply/divide by 2**amt on the operand's numeric value.
    function automatic exp_t model(input logic [W-1:0] a, input logic [1:0] op, input int amt);
        exp_t   e;
        longint ua, pw, full, sv, q;
        ua   = longint'(a);
        pw   = longint'(1) << amt;
        full = longint'(1) << W;
        e.sout = a; e.carry = 1'b0; e.due = 0;
        if (op == 2'b00 || amt == 0) return e;
        case (op)
            2'b01: begin
                q = ua * pw;
                e.sout  = W'(q % full);
                e.carry = ((q / full) % 2) != 0;
            end
            2'b10: begin
                e.sout  = W'(ua / pw);
                e.carry = ((ua / (pw / 2)) % 2) != 0;
            end
            default: begin
                sv = (ua >= full / 2) ? ua - full : ua;
                e.sout  = W'(fdiv(sv, pw));
                e.carry = (fdiv(sv, pw / 2) % 2) != 0;
            end
        endcase
        return e;
    endfunction

    function automatic int latency(input logic [1:0] op, input int amt);
`ifdef SHIFTER_BARREL_EN
        return 0;
`else
        return (op == 2'b00 || amt == 0) ? 0 : amt;
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [1:0] op, input int amt, input bit glitch);
        exp_t e;
        int   guard = 0;
        while (bus.busy !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_wait: busy stuck at %b, expected 0", bus.busy);
            return;
        end
        bus.start = 1'b1;
        bus.in    = a;
        bus.op    = op;
        bus.amt   = SW'(amt);
        e     = model(a, op, amt);
        e.due = cyc + 1 + latency(op, amt);
        sb.push_back(e);
        @(negedge clk);
        if (glitch) begin
            bus.in  = ~a;
            bus.op  = 2'($urandom_range(0, 3));
            bus.amt = SW'($urandom_range(1, W - 1));
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.in    = W'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_done) begin
                check("busy_after_done", 64'(bus.busy), 64'(0));
                check("sout_hold", 64'(bus.sout), 64'(last_sout));
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_done: done=1 with no request outstanding, expected 0");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sout", 64'(bus.sout), 64'(e.sout));
                    check("carry", 64'(bus.carry), 64'(e.carry));
                    check("done_cycle", 64'(cyc), 64'(e.due));
                    check("busy_in_done", 64'(bus.busy), 64'(1));
                    last_sout = e.sout;
                end
            end
            prev_done = bus.done;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        bus.start = 1'b1;
        bus.in    = 16'h1234;
        bus.op    = 2'b01;
        bus.amt   = 4'd3;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sout", 64'(bus.sout), 64'(0));
        check("rst_carry", 64'(bus.carry), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        rst_n = 1'b1;

        issue(16'h0001, 2'b01, 15, 1'b0);
        issue(16'hC000, 2'b01, 1, 1'b0);
        issue(16'h8001, 2'b11, 4, 1'b0);
        issue(16'h8008, 2'b10, 4, 1'b0);
        issue(16'hABCD, 2'b00, 7, 1'b0);
        issue(16'h5A5A, 2'b01, 0, 1'b0);
        drain();
        issue(16'h1357, 2'b10, 5, 1'b1);
        issue(16'h8642, 2'b00, 3, 1'b1);
        issue(16'hF00F, 2'b11, 1, 1'b1);
        drain();

        // Abort mid-shift: everything clears at once and no done follows.
        issue(16'h00FF, 2'b01, 10, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_sout", 64'(bus.sout), 64'(0));
        check("abort_carry", 64'(bus.carry), 64'(0));
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        last_sout = '0;

        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] a;
            logic [1:0]   op;
            int           amt;
            exp_t         m;
            sh_res_t      p;
            a   = W'($urandom);
            op  = 2'($urandom_range(0, 3));
            amt = $urandom_range(0, W - 1);
            m   = model(a, op, amt);
            p   = barrel_shift(MAX_W'(a), op, amt, W);
            check("pkg_vs_model", {p.data[W-1:0], p.carry}, {m.sout, m.carry});
            issue(a, op, amt, ($urandom_range(0, 3) == 0));
        end
        drain();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
